absorb_fsm: RTL and testbench

Second-stage controller of the SHAKE core. It consumes the input buffer that the load stage fills and owns the input-buffer-ready handshake flag. For each buffered block it XORs the block into the Keccak state, then runs the 24-round permutation. After the last block of a message it presents the state to the dump (squeeze) stage and runs extra permutations when that stage asks for more output.

---
 rtl/shake_pkg.sv | 30 +++
 rtl/absorb_fsm_if.sv | 59 +++++
 rtl/absorb_fsm_buffer_flag.sv | 50 +++++
 rtl/absorb_fsm.sv | 137 +++++++++++++
 tb/tb_absorb_fsm.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shake_pkg.sv
// -----------------------------------------------------------------------------
// shake_pkg
// Shared definitions for the SHAKE core controllers.
//   NUM_ROUNDS     : Keccak-f[1600] rounds per permutation
//   ROUND_W        : width of the round counter / round_index
//   absorb_state_t : one-hot state encoding of the absorb controller
// -----------------------------------------------------------------------------
package shake_pkg;

    localparam int NUM_ROUNDS = 24;
    localparam int ROUND_W    = 5;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    // One-hot: any encoding that is not exactly one of these falls into the
    // default branch of the next-state logic and recovers through RESET.
    typedef enum logic [5:0] {
        RESET        = 6'b000001,
        WAIT_BLOCK   = 6'b000010,
        ABSORB       = 6'b000100,
        PERMUTE      = 6'b001000,
        WAIT_SQUEEZE = 6'b010000,
        FINISH       = 6'b100000
    } absorb_state_t;

    function automatic logic is_last_round(input logic [ROUND_W-1:0] cnt);
        return cnt == LAST_ROUND;
    endfunction

endpackage

// File: rtl/absorb_fsm_if.sv
// -----------------------------------------------------------------------------
// absorb_fsm_if
// Handshake and control bundle between the absorb controller and its
// neighbours (load stage, dump stage, Keccak datapath).
//   master : the surrounding environment (load/dump stages, datapath)
//   slave  : the absorb controller itself
// Signals:
//   input_buffer_ready_wr   load -> ctrl  buffer filled pulse
//   last_block_in_buffer_wr load -> ctrl  qualifies the pulse: last block
//   input_buffer_ready      ctrl -> load  buffer occupied flag
//   state_reset             ctrl -> dp    zero the Keccak state
//   absorb_enable           ctrl -> dp    XOR buffer into rate lanes
//   round_enable            ctrl -> dp    apply one round
//   round_index             ctrl -> dp    round constant select
//   output_buffer_ready     ctrl -> dump  state is squeezable
//   squeeze_done            dump -> ctrl  state copied pulse
//   squeeze_more            dump -> ctrl  qualifies the pulse: need more
// -----------------------------------------------------------------------------
interface absorb_fsm_if;
    import shake_pkg::*;

    logic               input_buffer_ready_wr;
    logic               last_block_in_buffer_wr;
    logic               input_buffer_ready;
    logic               state_reset;
    logic               absorb_enable;
    logic               round_enable;
    logic [ROUND_W-1:0] round_index;
    logic               output_buffer_ready;
    logic               squeeze_done;
    logic               squeeze_more;

    modport master (
        output input_buffer_ready_wr,
        output last_block_in_buffer_wr,
        output squeeze_done,
        output squeeze_more,
        input  input_buffer_ready,
        input  state_reset,
        input  absorb_enable,
        input  round_enable,
        input  round_index,
        input  output_buffer_ready
    );

    modport slave (
        input  input_buffer_ready_wr,
        input  last_block_in_buffer_wr,
        input  squeeze_done,
        input  squeeze_more,
        output input_buffer_ready,
        output state_reset,
        output absorb_enable,
        output round_enable,
        output round_index,
        output output_buffer_ready
    );

endinterface

// File: rtl/absorb_fsm_buffer_flag.sv
// -----------------------------------------------------------------------------
// buffer_flag
// Set/clear flag with set priority plus a side bit captured on set.
//   clk, rst : clock, synchronous active-high reset (clears both bits)
//   set_i    : set the flag and capture side_i
//   clr_i    : clear the flag (loses to set_i in the same cycle)
//   side_i   : qualifier sampled together with set_i
//   flag_o   : flag state
//   side_o   : last captured qualifier
// -----------------------------------------------------------------------------
module buffer_flag (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    input  logic side_i,
    output logic flag_o,
    output logic side_o
);

    logic flag_q, flag_d;
    logic side_q, side_d;

    always_comb begin
        flag_d = flag_q;
        side_d = side_q;
        if (clr_i) begin
            flag_d = 1'b0;
        end
        // Set is evaluated last so it overrides a coincident clear.
        if (set_i) begin
            flag_d = 1'b1;
            side_d = side_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            side_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            side_q <= side_d;
        end
    end

    assign flag_o = flag_q;
    assign side_o = side_q;

endmodule

// File: rtl/absorb_fsm.sv
// -----------------------------------------------------------------------------
// absorb_fsm
// Second-stage SHAKE controller: absorbs each buffered block into the Keccak
// state (one XOR cycle followed by NUM_ROUNDS round cycles), then hands the
// state to the dump stage and runs extra permutations on request.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   ctl : absorb_fsm_if.slave handshake/control bundle
// All outputs except input_buffer_ready are Moore-decoded from the state.
// -----------------------------------------------------------------------------
module absorb_fsm
    import shake_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    absorb_fsm_if.slave  ctl
);

    absorb_state_t      state_q, state_d;
    logic [ROUND_W-1:0] cnt_q, cnt_d;
    logic               squeezing_q, squeezing_d;

    logic               flag;
    logic               last_reg;
    logic               flag_clr;

    logic               state_reset;
    logic               absorb_enable;
    logic               round_enable;
    logic [ROUND_W-1:0] round_index;
    logic               output_buffer_ready;

    // Input-buffer-ready flag with the "last block" qualifier alongside.
    buffer_flag u_in_flag (
        .clk    (clk),
        .rst    (rst),
        .set_i  (ctl.input_buffer_ready_wr),
        .clr_i  (flag_clr),
        .side_i (ctl.last_block_in_buffer_wr),
        .flag_o (flag),
        .side_o (last_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET;
            cnt_q       <= '0;
            squeezing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            squeezing_q <= squeezing_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        squeezing_d         = squeezing_q;
        flag_clr            = 1'b0;
        state_reset         = 1'b0;
        absorb_enable       = 1'b0;
        round_enable        = 1'b0;
        round_index         = '0;
        output_buffer_ready = 1'b0;

        case (state_q)
            RESET: begin
                state_reset = 1'b1;
                state_d     = WAIT_BLOCK;
            end

            WAIT_BLOCK: begin
                if (flag) begin
                    state_d = ABSORB;
                end
            end

            ABSORB: begin
                absorb_enable = 1'b1;
                flag_clr      = 1'b1;
                cnt_d         = '0;
                state_d       = PERMUTE;
            end

            PERMUTE: begin
                round_enable = 1'b1;
                round_index  = cnt_q;
                if (is_last_round(cnt_q)) begin
                    // Park the counter at 0 so it never runs past the last round.
                    cnt_d = '0;
                    // A squeeze permutation always returns to the dump stage,
                    // even if a next-message block has since rewritten last_reg.
                    if (squeezing_q || last_reg) begin
                        state_d = WAIT_SQUEEZE;
                    end else begin
                        state_d = WAIT_BLOCK;
                    end
                end else begin
                    cnt_d = cnt_q + ROUND_W'(1);
                end
            end

            WAIT_SQUEEZE: begin
                output_buffer_ready = 1'b1;
                if (ctl.squeeze_done) begin
                    if (ctl.squeeze_more) begin
                        squeezing_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = PERMUTE;
                    end else begin
                        squeezing_d = 1'b0;
                        state_d     = FINISH;
                    end
                end
            end

            FINISH: begin
                // Zero the state before any pending next-message block is absorbed.
                state_reset = 1'b1;
                state_d     = WAIT_BLOCK;
            end

            default: begin
                state_d = RESET;
            end
        endcase
    end

    assign ctl.input_buffer_ready  = flag;
    assign ctl.state_reset         = state_reset;
    assign ctl.absorb_enable       = absorb_enable;
    assign ctl.round_enable        = round_enable;
    assign ctl.round_index         = round_index;
    assign ctl.output_buffer_ready = output_buffer_ready;

endmodule

// File: tb/tb_absorb_fsm.sv
// -----------------------------------------------------------------------------
// tb_absorb_fsm
// Directed bench for absorb_fsm. The stimulus process drives inputs and
// pushes the expected output vector for each cycle of interest into a
// cycle-ordered scoreboard; a monitor pops and compares at each negedge.
// Output vector: {ibr, state_reset, absorb_en, round_en, round_index, obr}
// -----------------------------------------------------------------------------
module tb_absorb_fsm;
    import shake_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    absorb_fsm_if bus ();

    absorb_fsm dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [9:0] v;
    } exp_t;

    exp_t q[$];

    int   total = 0;
    int   bad   = 0;
    logic fin_req = 1'b0;
    logic fin_ack = 1'b0;

    wire logic [9:0] outv = {bus.input_buffer_ready, bus.state_reset,
                             bus.absorb_enable, bus.round_enable,
                             bus.round_index, bus.output_buffer_ready};

    function automatic logic [9:0] mk(input bit ibr, input bit sr, input bit ab,
                                      input bit re, input int ri, input bit obr);
        logic [4:0] r;
        r = 5'(ri);
        return {ibr, sr, ab, re, r, obr};
    endfunction

    // Insert keeping the queue ordered by cycle.
    task automatic push(input int c, input logic [9:0] v);
        int   i;
        exp_t e;
        i = 0;
        while (i < q.size() && q[i].c <= c) i++;
        e.c = c;
        e.v = v;
        q.insert(i, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL stale@%0d expectation for cycle %0d never checked, want=%b",
                     cyc, e.c, e.v);
        end
        while (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            total = total + 1;
            if (outv !== e.v) begin
                bad = bad + 1;
                $display("FAIL outvec@%0d got=%b want=%b", cyc, outv, e.v);
            end
        end
        if (fin_req && !fin_ack) begin
            total = total + 1;
            if (q.size() != 0) begin
                bad = bad + 1;
                $display("FAIL leftover got=%0d entries want=0", q.size());
            end
            fin_ack <= 1'b1;
        end
    end

    // Double write into an occupied buffer is a load-stage protocol violation.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.input_buffer_ready_wr && bus.input_buffer_ready))
                else $error("protocol violation: buffer write while input_buffer_ready=1");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s, s2, t2, u, w, d, e;
        rst                         = 1'b1;
        bus.input_buffer_ready_wr   = 1'b0;
        bus.last_block_in_buffer_wr = 1'b0;
        bus.squeeze_done            = 1'b0;
        bus.squeeze_more            = 1'b0;

        // Reset held through cycle 3; state_reset only, everything else low.
        for (int c = 1; c <= 3; c++) push(c, mk(0, 1, 0, 0, 0, 0));
        push(4, mk(0, 0, 0, 0, 0, 0));
        step_to(3);
        rst = 1'b0;

        // Single last block written at t=5.
        t = 5;
        push(t, mk(0, 0, 0, 0, 0, 0));
        push(t + 1, mk(1, 0, 0, 0, 0, 0));
        push(t + 2, mk(1, 0, 1, 0, 0, 0));
        for (int k = 0; k < 24; k++) push(t + 3 + k, mk(0, 0, 0, 1, k, 0));
        for (int k = 27; k <= 29; k++) push(t + k, mk(0, 0, 0, 0, 0, 1));
        step_to(t);
        bus.input_buffer_ready_wr   = 1'b1;
        bus.last_block_in_buffer_wr = 1'b1;
        step();
        bus.input_buffer_ready_wr   = 1'b0;
        bus.last_block_in_buffer_wr = 1'b0;

        // Extra squeeze permutation: rounds without absorb.
        s = t + 30;
        push(s, mk(0, 0, 0, 0, 0, 1));
        for (int k = 0; k < 24; k++) push(s + 1 + k, mk(0, 0, 0, 1, k, 0));
        push(s + 25, mk(0, 0, 0, 0, 0, 1));
        push(s + 26, mk(0, 0, 0, 0, 0, 1));
        step_to(s);
        bus.squeeze_done = 1'b1;
        bus.squeeze_more = 1'b1;
        step();
        bus.squeeze_done = 1'b0;
        bus.squeeze_more = 1'b0;

        // Final squeeze: one FINISH cycle then idle.
        s2 = s + 27;
        push(s2, mk(0, 0, 0, 0, 0, 1));
        push(s2 + 1, mk(0, 1, 0, 0, 0, 0));
        push(s2 + 2, mk(0, 0, 0, 0, 0, 0));
        push(s2 + 3, mk(0, 0, 0, 0, 0, 0));
        step_to(s2);
        bus.squeeze_done = 1'b1;
        step();
        bus.squeeze_done = 1'b0;

        // Two-block message: first block not last, returns to WAIT_BLOCK.
        t2 = s2 + 5;
        push(t2 + 1, mk(1, 0, 0, 0, 0, 0));
        push(t2 + 2, mk(1, 0, 1, 0, 0, 0));
        for (int k = 0; k < 24; k++) push(t2 + 3 + k, mk(0, 0, 0, 1, k, 0));
        for (int k = 27; k <= 35; k++) push(t2 + k, mk(0, 0, 0, 0, 0, 0));
        step_to(t2);
        bus.input_buffer_ready_wr   = 1'b1;
        bus.last_block_in_buffer_wr = 1'b0;
        step();
        bus.input_buffer_ready_wr   = 1'b0;

        u = t2 + 35;
        push(u + 1, mk(1, 0, 0, 0, 0, 0));
        push(u + 2, mk(1, 0, 1, 0, 0, 0));
        for (int k = 0; k < 24; k++) push(u + 3 + k, mk(0, 0, 0, 1, k, 0));
        push(u + 27, mk(0, 0, 0, 0, 0, 1));
        push(u + 28, mk(0, 0, 0, 0, 0, 1));
        step_to(u);
        bus.input_buffer_ready_wr   = 1'b1;
        bus.last_block_in_buffer_wr = 1'b1;
        step();
        bus.input_buffer_ready_wr   = 1'b0;
        bus.last_block_in_buffer_wr = 1'b0;

        // Back-to-back: next message written during WAIT_SQUEEZE, absorbed after FINISH.
        w = u + 29;
        push(w, mk(0, 0, 0, 0, 0, 1));
        push(w + 1, mk(1, 0, 0, 0, 0, 1));
        d = w + 2;
        push(d, mk(1, 0, 0, 0, 0, 1));
        push(d + 1, mk(1, 1, 0, 0, 0, 0));
        push(d + 2, mk(1, 0, 0, 0, 0, 0));
        push(d + 3, mk(1, 0, 1, 0, 0, 0));
        for (int k = 0; k < 24; k++) push(d + 4 + k, mk(0, 0, 0, 1, k, 0));
        push(d + 28, mk(0, 0, 0, 0, 0, 1));
        step_to(w);
        bus.input_buffer_ready_wr   = 1'b1;
        bus.last_block_in_buffer_wr = 1'b1;
        step();
        bus.input_buffer_ready_wr   = 1'b0;
        bus.last_block_in_buffer_wr = 1'b0;
        step_to(d);
        bus.squeeze_done = 1'b1;
        bus.squeeze_more = 1'b0;
        step();
        bus.squeeze_done = 1'b0;

        // Reset at round_index=10 of a squeeze permutation with a pending block.
        e = d + 30;
        push(e, mk(0, 0, 0, 0, 0, 1));
        for (int k = 0; k <= 10; k++)
            push(e + 1 + k, mk((e + 1 + k) >= (e + 4), 0, 0, 1, k, 0));
        push(e + 12, mk(0, 1, 0, 0, 0, 0));
        for (int k = 13; k <= 17; k++) push(e + k, mk(0, 0, 0, 0, 0, 0));
        step_to(e);
        bus.squeeze_done = 1'b1;
        bus.squeeze_more = 1'b1;
        step();
        bus.squeeze_done = 1'b0;
        bus.squeeze_more = 1'b0;
        step_to(e + 3);
        bus.input_buffer_ready_wr   = 1'b1;
        bus.last_block_in_buffer_wr = 1'b0;
        step();
        bus.input_buffer_ready_wr   = 1'b0;
        step_to(e + 11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        // Stray squeeze_done in WAIT_BLOCK must be ignored.
        step_to(e + 14);
        bus.squeeze_done = 1'b1;
        bus.squeeze_more = 1'b1;
        step();
        bus.squeeze_done = 1'b0;
        bus.squeeze_more = 1'b0;

        step_to(e + 20);
        fin_req = 1'b1;
        for (int i = 0; i < 5 && !fin_ack; i++) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
